// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
//   Control stage between a UART receiver and an ALU/UART transmitter.
//   It collects operand A, operand B and an opcode from three received bytes.
//   It presents them to an external combinational ALU and captures the result.
//   It then starts the transmitter with a one-cycle pulse and waits for it to finish.
//   Corrupt, late or out-of-turn bytes are discarded and counted, and the count saturates.
//
// Ports
//   i_clock          system clock
//   i_reset          synchronous reset, active-low
//   i_rx_done        one-cycle pulse, i_rx_data/i_rx_parity_err valid
//   i_rx_data        received byte
//   i_rx_parity_err  parity error flag for the current byte
//   i_alu_result     combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   o_alu_a/b/op     operands and opcode presented to the ALU
//   o_tx_signal      one-cycle transmit start pulse
//   o_tx_data        byte to transmit, held until the next transaction
//   i_tx_done        one-cycle pulse, transmitter finished
//   o_busy           high whenever a transaction is in progress
//   o_drop           one-cycle pulse per discarded byte or transaction
//   o_drop_count     saturating count of o_drop pulses
module uart_alu_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_parity_err,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_signal,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_drop,
  output logic [CNT_WIDTH-1:0]  o_drop_count
);

  // TIMEOUT_CYCLES-1 is the largest value the counter ever holds.
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OP1,
    S_OP2,
    S_OPC,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_signal_q, tx_signal_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic rx_accept;
  logic tmo_expired;

  assign rx_accept   = i_rx_done & ~i_rx_parity_err;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_expired = (tmo_q == TMO_LAST) & ~i_rx_done;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    tx_data_d   = tx_data_q;
    tx_signal_d = 1'b0;
    drop_d      = 1'b0;

    case (state_q)
      S_OP1: begin
        if (rx_accept) begin
          alu_a_d = i_rx_data;
          state_d = S_OP2;
        end else if (i_rx_done) begin
          drop_d = 1'b1;
        end
      end
      S_OP2: begin
        if (rx_accept) begin
          alu_b_d = i_rx_data;
          state_d = S_OPC;
        end else if (i_rx_done || tmo_expired) begin
          drop_d  = 1'b1;
          state_d = S_OP1;
        end
      end
      S_OPC: begin
        if (rx_accept) begin
          alu_op_d = i_rx_data[OP_WIDTH-1:0];
          state_d  = S_EXEC;
        end else if (i_rx_done || tmo_expired) begin
          drop_d  = 1'b1;
          state_d = S_OP1;
        end
      end
      S_EXEC: begin
        tx_data_d = i_alu_result;
        drop_d    = i_rx_done;
        state_d   = S_SEND;
      end
      S_SEND: begin
        // Registered, so the pulse appears in the cycle after leaving S_SEND.
        tx_signal_d = 1'b1;
        drop_d      = i_rx_done;
        state_d     = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        drop_d = i_rx_done;
        if (i_tx_done) begin
          state_d = S_OP1;
        end
      end
      default: begin
        state_d = S_OP1;
      end
    endcase

    busy_d = (state_d != S_OP1);

    if (drop_d && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end else begin
      drop_count_d = drop_count_q;
    end

    // The counter restarts on every state change and only runs while
    // waiting for operand B or the opcode.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == S_OP2) || (state_q == S_OPC)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= S_OP1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tx_data_q    <= '0;
      tx_signal_q  <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
      drop_count_q <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tx_data_q    <= tx_data_d;
      tx_signal_q  <= tx_signal_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_signal  = tx_signal_q;
  assign o_busy       = busy_q;
  assign o_drop       = drop_q;
  assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer
//   Drives byte-level transactions into uart_alu_sequencer.
//   Expected results come from an arithmetic ALU reference and a simple tally of discarded bytes.
//   A shortened timeout is used so the timeout boundary can be hit exactly.
module tb_uart_alu_sequencer;
  localparam int DW = 8;
  localparam int OW = 6;
  localparam int TO = 100;
  localparam int CW = 8;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_rx_done;
  logic [DW-1:0] i_rx_data;
  logic          i_rx_parity_err;
  logic [DW-1:0] i_alu_result;
  logic [DW-1:0] o_alu_a;
  logic [DW-1:0] o_alu_b;
  logic [OW-1:0] o_alu_op;
  logic          o_tx_signal;
  logic [DW-1:0] o_tx_data;
  logic          i_tx_done;
  logic          o_busy;
  logic          o_drop;
  logic [CW-1:0] o_drop_count;

  always #5 i_clock = ~i_clock;

  uart_alu_sequencer #(
    .DATA_WIDTH    (DW),
    .OP_WIDTH      (OW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_rx_done      (i_rx_done),
    .i_rx_data      (i_rx_data),
    .i_rx_parity_err(i_rx_parity_err),
    .i_alu_result   (i_alu_result),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .o_alu_op       (o_alu_op),
    .o_tx_signal    (o_tx_signal),
    .o_tx_data      (o_tx_data),
    .i_tx_done      (i_tx_done),
    .o_busy         (o_busy),
    .o_drop         (o_drop),
    .o_drop_count   (o_drop_count)
  );

  // Reference ALU: MIPS-style function codes.
  function automatic logic [DW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return DW'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return '0;
    endcase
  endfunction

  always_comb i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_drops = 0;
  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
    return (exp_drops > 255) ? 32'd255 : 32'(exp_drops);
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input logic perr);
    i_rx_done       = 1'b1;
    i_rx_data       = d;
    i_rx_parity_err = perr;
    tick();
    i_rx_done       = 1'b0;
    i_rx_parity_err = 1'b0;
    i_rx_data       = DW'($urandom);
  endtask

  // Corrupt byte while idle: always discarded.
  task automatic drop_byte(input string tag);
    send_byte(DW'($urandom), 1'b1);
    exp_drops++;
    check_value({tag, "_drop"}, 32'(o_drop), 32'd1);
    check_value({tag, "_cnt"}, 32'(o_drop_count), exp_count());
  endtask

  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] opb,
                         input int gap, input bit oot);
    logic [DW-1:0] exp;
    exp = alu_model(a, b, opb[OW-1:0]);
    send_byte(a, 1'b0);
    check_value("alu_a", 32'(o_alu_a), 32'(a));
    check_value("busy_a", 32'(o_busy), 32'd1);
    idle(gap);
    send_byte(b, 1'b0);
    check_value("alu_b", 32'(o_alu_b), 32'(b));
    check_value("drop_b", 32'(o_drop), 32'd0);
    idle(gap);
    send_byte(opb, 1'b0);
    check_value("alu_op", 32'(o_alu_op), 32'(opb[OW-1:0]));
    check_value("drop_op", 32'(o_drop), 32'd0);
    check_value("txsig_n0", 32'(o_tx_signal), 32'd0);
    tick();
    check_value("tx_data", 32'(o_tx_data), 32'(exp));
    check_value("txsig_n1", 32'(o_tx_signal), 32'd0);
    tick();
    check_value("txsig_n2", 32'(o_tx_signal), 32'd1);
    tick();
    check_value("txsig_n3", 32'(o_tx_signal), 32'd0);
    check_value("busy_wait", 32'(o_busy), 32'd1);
    if (oot) begin
      send_byte(8'h55, 1'b0);
      exp_drops++;
      check_value("oot_drop", 32'(o_drop), 32'd1);
      check_value("oot_tx_data", 32'(o_tx_data), 32'(exp));
      check_value("oot_alu_a", 32'(o_alu_a), 32'(a));
      check_value("oot_cnt", 32'(o_drop_count), exp_count());
    end
    idle($urandom_range(0, 3));
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check_value("busy_done", 32'(o_busy), 32'd0);
    check_value("drop_done", 32'(o_drop), 32'd0);
    $display("txn a=0x%02h b=0x%02h op=0x%02h gap=%0d oot=%0d expected=0x%02h got=0x%02h",
             a, b, opb, gap, oot, exp, o_tx_data);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_a"}, 32'(o_alu_a), 32'd0);
    check_value({tag, "_b"}, 32'(o_alu_b), 32'd0);
    check_value({tag, "_op"}, 32'(o_alu_op), 32'd0);
    check_value({tag, "_txd"}, 32'(o_tx_data), 32'd0);
    check_value({tag, "_txs"}, 32'(o_tx_signal), 32'd0);
    check_value({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_value({tag, "_drop"}, 32'(o_drop), 32'd0);
    check_value({tag, "_cnt"}, 32'(o_drop_count), 32'd0);
  endtask

  initial begin
    i_reset         = 1'b0;
    i_rx_done       = 1'b0;
    i_rx_data       = '0;
    i_rx_parity_err = 1'b0;
    i_tx_done       = 1'b0;
    idle(2);
    check_all_zero("reset");
    i_reset = 1'b1;
    idle(2);

    // Normal ADD.
    run_txn(8'h12, 8'h34, 8'h20, 0, 1'b0);

    // Parity error on operand B, then a SUB.
    send_byte(8'h05, 1'b0);
    send_byte(8'h07, 1'b1);
    exp_drops++;
    check_value("perr_drop", 32'(o_drop), 32'd1);
    check_value("perr_cnt", 32'(o_drop_count), exp_count());
    check_value("perr_busy", 32'(o_busy), 32'd0);
    tick();
    check_value("perr_drop_once", 32'(o_drop), 32'd0);
    run_txn(8'h0A, 8'h03, 8'h22, 0, 1'b0);

    // Timeout after operand A.
    send_byte(8'h99, 1'b0);
    idle(TO - 1);
    check_value("tmo_pre_drop", 32'(o_drop), 32'd0);
    check_value("tmo_pre_busy", 32'(o_busy), 32'd1);
    idle(1);
    exp_drops++;
    check_value("tmo_drop", 32'(o_drop), 32'd1);
    check_value("tmo_busy", 32'(o_busy), 32'd0);
    check_value("tmo_cnt", 32'(o_drop_count), exp_count());

    // Bytes arriving exactly on the expiry cycle are accepted.
    run_txn(DW'($urandom), DW'($urandom), {2'b01, ops[$urandom_range(0, 7)]}, TO - 1, 1'b0);

    // Out-of-turn byte while waiting on the transmitter.
    run_txn(8'h21, 8'h0F, 8'h24, 1, 1'b1);
    run_txn(8'h3C, 8'h02, 8'h02, 0, 1'b0);

    // Reset in S_OPC.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    exp_drops = 0;
    check_all_zero("midreset");
    run_txn(8'h81, 8'h01, 8'h20, 0, 1'b0);

    // Opcode upper bits ignored (SRA).
    run_txn(8'hF0, 8'h02, 8'hC3, 0, 1'b0);

    // Randomized transactions, with occasional corrupt bytes and late bytes.
    for (int t = 0; t < 20; t++) begin
      int k;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) drop_byte("rnd_idle");
      run_txn(DW'($urandom), DW'($urandom),
              {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]},
              $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end

    // Saturation of the drop counter.
    for (int j = 0; j < 300; j++) begin
      send_byte(DW'($urandom), 1'b1);
      exp_drops++;
    end
    check_value("sat_drop", 32'(o_drop), 32'd1);
    check_value("sat_cnt", 32'(o_drop_count), exp_count());
    idle(3);
    check_value("sat_hold", 32'(o_drop_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
